// File: rtl/alu_rs_issue.sv
// ALU reservation station: collapsing age-ordered queue with CDB wakeup and oldest-ready issue.
// Optional macro ALU_RS_WAKEUP_BYPASS_EN makes a same-cycle CDB match count as ready, forwarding cdb_val_i.
module alu_rs_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int AE_W  = 107 + TAG_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [AE_W-1:0]  disp_data_i,
    input  logic             disp_rs1_rdy_i,
    input  logic             disp_rs2_rdy_i,
    input  logic [TAG_W-1:0] disp_rs1_tag_i,
    input  logic [TAG_W-1:0] disp_rs2_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_val_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [AE_W-1:0]  issue_data_o,
    output logic [CNT_W-1:0] count_o
);

    typedef struct packed {
        logic [3:0]       aluop;
        logic [31:0]      rs1_val;
        logic [31:0]      rs2_val;
        logic [31:0]      imm_val;
        logic             rs2_used;
        logic             imm_used;
        logic [4:0]       rd_addr;
        logic [TAG_W-1:0] rob_tag;
    } ae_t;

    ae_t              r_ent  [DEPTH];
    logic [TAG_W-1:0] r_tag1 [DEPTH];
    logic [TAG_W-1:0] r_tag2 [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_rdy1;
    logic [DEPTH-1:0] r_rdy2;
    logic [CNT_W-1:0] r_count;

    ae_t              w_ent_nxt  [DEPTH];
    logic [TAG_W-1:0] w_tag1_nxt [DEPTH];
    logic [TAG_W-1:0] w_tag2_nxt [DEPTH];
    logic [DEPTH-1:0] w_vld_nxt;
    logic [DEPTH-1:0] w_rdy1_nxt;
    logic [DEPTH-1:0] w_rdy2_nxt;

    logic [DEPTH-1:0] w_byp1;
    logic [DEPTH-1:0] w_byp2;
    logic [DEPTH-1:0] w_ent_rdy;
    logic             w_any_rdy;
    logic [IDX_W-1:0] w_sel;
    ae_t              w_issue_ent;
    ae_t              w_disp_ent;
    logic             w_issue_fire;
    logic             w_disp_fire;
    logic [CNT_W-1:0] w_widx;

    assign w_disp_ent    = disp_data_i;
    assign disp_ready_o  = !flush_i && (r_count < CNT_W'(DEPTH));
    assign issue_valid_o = !flush_i && w_any_rdy;
    assign issue_data_o  = issue_valid_o ? w_issue_ent : '0;
    assign count_o       = r_count;
    assign w_issue_fire  = issue_valid_o && issue_ready_i;
    assign w_disp_fire   = disp_valid_i && disp_ready_o;
    // A same-cycle issue shifts the queue down, so the free slot moves down too.
    assign w_widx        = r_count - CNT_W'(w_issue_fire);

    always_comb begin
        w_byp1    = '0;
        w_byp2    = '0;
        w_ent_rdy = '0;
        w_sel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            w_byp1[i] = cdb_valid_i && !r_rdy1[i] && (r_tag1[i] == cdb_tag_i);
            w_byp2[i] = cdb_valid_i && !r_rdy2[i] && (r_tag2[i] == cdb_tag_i);
`endif
            w_ent_rdy[i] = r_vld[i] && (r_rdy1[i] || w_byp1[i]) &&
                           (!r_ent[i].rs2_used || r_rdy2[i] || w_byp2[i]);
        end
        // Descending scan leaves the lowest (oldest) ready index selected.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ent_rdy[i]) w_sel = IDX_W'(i);
        end
        w_any_rdy = |w_ent_rdy;
    end

    always_comb begin
        w_issue_ent = r_ent[w_sel];
        if (w_byp1[w_sel]) w_issue_ent.rs1_val = cdb_val_i;
        if (w_byp2[w_sel]) w_issue_ent.rs2_val = cdb_val_i;
    end

    always_comb begin
        int src;
        int src_c;
        for (int i = 0; i < DEPTH; i++) begin
            src   = (w_issue_fire && (i >= int'(w_sel))) ? i + 1 : i;
            src_c = (src < DEPTH) ? src : DEPTH - 1;
            w_vld_nxt[i]  = (src < DEPTH) && r_vld[src_c];
            w_ent_nxt[i]  = r_ent[src_c];
            w_rdy1_nxt[i] = r_rdy1[src_c];
            w_rdy2_nxt[i] = r_rdy2[src_c];
            w_tag1_nxt[i] = r_tag1[src_c];
            w_tag2_nxt[i] = r_tag2[src_c];
            // Wakeup is applied after the collapse so the issued entry is never touched.
            if (w_vld_nxt[i] && cdb_valid_i && !w_rdy1_nxt[i] && (w_tag1_nxt[i] == cdb_tag_i)) begin
                w_rdy1_nxt[i]         = 1'b1;
                w_ent_nxt[i].rs1_val  = cdb_val_i;
            end
            if (w_vld_nxt[i] && cdb_valid_i && !w_rdy2_nxt[i] && (w_tag2_nxt[i] == cdb_tag_i)) begin
                w_rdy2_nxt[i]         = 1'b1;
                w_ent_nxt[i].rs2_val  = cdb_val_i;
            end
            if (w_disp_fire && (w_widx == CNT_W'(i))) begin
                w_vld_nxt[i]  = 1'b1;
                w_ent_nxt[i]  = w_disp_ent;
                w_rdy1_nxt[i] = disp_rs1_rdy_i;
                w_rdy2_nxt[i] = disp_rs2_rdy_i;
                w_tag1_nxt[i] = disp_rs1_tag_i;
                w_tag2_nxt[i] = disp_rs2_tag_i;
                if (cdb_valid_i && !disp_rs1_rdy_i && (disp_rs1_tag_i == cdb_tag_i)) begin
                    w_rdy1_nxt[i]        = 1'b1;
                    w_ent_nxt[i].rs1_val = cdb_val_i;
                end
                if (cdb_valid_i && !disp_rs2_rdy_i && (disp_rs2_tag_i == cdb_tag_i)) begin
                    w_rdy2_nxt[i]        = 1'b1;
                    w_ent_nxt[i].rs2_val = cdb_val_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_count <= r_count + CNT_W'(w_disp_fire) - CNT_W'(w_issue_fire);
        end
    end

    // Payload and operand status are qualified by r_vld, so they carry no reset.
    always_ff @(posedge clk_i) begin
        r_ent  <= w_ent_nxt;
        r_tag1 <= w_tag1_nxt;
        r_tag2 <= w_tag2_nxt;
        r_rdy1 <= w_rdy1_nxt;
        r_rdy2 <= w_rdy2_nxt;
    end

endmodule

// File: doc/alu_rs_issue.md
Name: alu_rs_issue

Overview:
- Reservation station feeding the ALU functional unit; it is the initiator side of the ALU request valid/ready handshake.
- Buffers dispatched ALU ops (alu_entry_t) in a collapsing age-ordered queue.
- Captures missing source operands from the CDB, then issues the oldest fully-ready entry to the ALU.
- Sits between dispatch/rename and the ALU; flushed on mispredict together with the ALU.

Parameters:
- AE, alu_entry_t, issue payload type (aluop, rs1_val, rs2_val, imm_val, rs2_used, imm_used, rd_addr, ROB_tag).
- DEPTH, 4, number of entries (>=2).
- TAG_W, 4, ROB/CDB tag width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drop all entries.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  slot available.
- disp_data_i  in  AE  entry payload; rs1_val/rs2_val meaningful only when the matching rdy bit is 1.
- disp_rs1_rdy_i  in  1  rs1 value present.
- disp_rs2_rdy_i  in  1  rs2 value present; ignored when rs2_used=0.
- disp_rs1_tag_i  in  TAG_W  producer tag for rs1.
- disp_rs2_tag_i  in  TAG_W  producer tag for rs2.
- cdb_valid_i  in  1  CDB broadcast.
- cdb_tag_i  in  TAG_W  broadcast tag.
- cdb_val_i  in  32  broadcast value.
- issue_valid_o  out  1  oldest ready entry presented.
- issue_ready_i  in  1  ALU req_ready.
- issue_data_o  out  AE  issued payload, operand values filled in.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (synchronous, reset_i=1 at posedge): all entry valid bits 0; count_o=0.
  - Outputs in the cycle after reset: disp_ready_o=1, issue_valid_o=0, issue_data_o='0.
- Per entry state: valid, AE payload, rs1_rdy, rs2_rdy, rs1_tag, rs2_tag. Index 0 holds the oldest entry.
- Entry ready = valid && rs1_rdy && (!rs2_used || rs2_rdy).
- Issue select:
  - issue_valid_o = !flush_i && any entry ready.
  - Selected entry = lowest-index ready entry.
  - issue_data_o = that entry's payload; '0 when issue_valid_o=0.
  - issue_valid_o never depends on issue_ready_i.
- Issue fire = issue_valid_o && issue_ready_i.
  - At the edge the selected entry is removed; entries above it shift down one slot, preserving age order.
- Dispatch:
  - disp_ready_o = !flush_i && count_o<DEPTH. Registered occupancy only; a same-cycle issue does not free a slot.
  - Dispatch fire = disp_valid_i && disp_ready_o.
  - New entry is written at index count_o, or count_o-1 if an issue fires in the same cycle.
- Wakeup, per valid entry each cycle:
  - If cdb_valid_i, the entry's rsN_rdy=0, and rsN_tag==cdb_tag_i: set rsN_rdy=1 and rsN_val=cdb_val_i at the edge.
  - Applies independently to rs1 and rs2; both may wake from one broadcast.
  - Baseline: a woken entry becomes issuable the next cycle.
- Dispatch-cycle wakeup: a dispatched operand with rdy=0 whose tag matches the same-cycle CDB broadcast is written as ready with cdb_val_i. No lost wakeup.
- Already-ready operands ignore the CDB.
- Simultaneous issue, dispatch and wakeup in one cycle:
  - All three apply.
  - Wakeup applies to entries after their shift.
  - The issued entry is not updated.
- count_o next = count_o + dispatch_fire - issue_fire.
- Flush (flush_i=1 at posedge): all entries invalidated, count_o=0; overrides dispatch, issue and wakeup in that cycle. Reset has priority over flush.
- Full (count_o==DEPTH): dispatch stalls. Empty: issue_valid_o=0.
- No X propagation: payload of invalid entries is never driven out.

Optional Feature:
- Macro: ALU_RS_WAKEUP_BYPASS_EN.
- Defined: an entry missing only the operand(s) matched by the current CDB broadcast counts as ready this cycle.
  - issue_data_o carries cdb_val_i forwarded into the matching field(s).
  - Age priority is unchanged.
  - On issue fire the forwarded value is what leaves; the entry is removed normally.
- Undefined: 1-cycle wakeup-to-issue latency as in Behaviour.

Test Plan:
- Reset, then dispatch ADD (rs1=5, rs2=7, both rdy, rs2_used=1) with issue_ready_i=1.
  - Next cycle issue_valid_o=1, issue_data_o.rs1_val=5, rs2_val=7.
  - Following cycle count_o=0.
- Dispatch entry A (rs1_rdy=0, tag 3), then B fully ready.
  - B issues first.
  - CDB tag 3, val 0x10 wakes A; A issues the next cycle with rs1_val=0x10 (same cycle with bypass macro).
- Fill DEPTH=4 with unready entries.
  - disp_ready_o=0; a 5th dispatch is held.
  - Wake entry 2: it issues; count_o=3; disp_ready_o=1 next cycle; entries 0,1,3 keep order.
- Dispatch an op with rs2 tag 5 while CDB broadcasts tag 5, val 0xAB.
  - Entry is ready next cycle; issue_data_o.rs2_val=0xAB.
- Three entries valid, flush_i=1 concurrently with disp_valid_i=1 and issue_ready_i=1.
  - issue_valid_o=0 and disp_ready_o=0 that cycle.
  - Next cycle count_o=0; no entry issued.
- issue_ready_i=0 for 3 cycles with a ready entry: issue_valid_o and issue_data_o stay stable. Assert reset_i mid-stall: next cycle count_o=0, issue_valid_o=0.
